// File: rtl/mesh_fifo_ovf_monitor.sv
// Overflow monitor for the mesh router-interface output FIFOs: sticky flags, saturating counts,
// first-overflow data capture and first-offender tracking. Optional macro FIFO_HWM_EN adds high-water marks.
module mesh_fifo_ovf_monitor #(
   parameter int NCH        = 64,
   parameter int PCKG_SZ    = 40,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 8,
   localparam int CW        = $clog2(FIFO_DEPTH) + 1,
   localparam int IW        = $clog2(NCH)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NCH-1:0]         push,
   input  logic [NCH*CW-1:0]      count,
   input  logic [NCH*PCKG_SZ-1:0] data,
   input  logic                   clr,
   input  logic [IW-1:0]          clr_ch,
   input  logic [IW-1:0]          rd_ch,
   output logic [NCH-1:0]         ovf_flag,
   output logic                   any_ovf,
   output logic [IW-1:0]          first_ch,
   output logic [CNT_W-1:0]       rd_cnt,
   output logic [PCKG_SZ-1:0]     rd_data,
   output logic [CW-1:0]          rd_hwm
);

   logic [NCH-1:0]     ev;
   logic [NCH-1:0]     clr_hit;
   logic [IW-1:0]      low_ev;
   logic               ev_found;
   logic [CNT_W-1:0]   cnt [NCH];
   logic [PCKG_SZ-1:0] cap [NCH];
   logic [CNT_W-1:0]   rd_cnt_sel;
   logic [PCKG_SZ-1:0] rd_data_sel;

   // Occupancy above depth cannot happen in a sane FIFO; it is treated as full.
   always_comb begin
      ev          = '0;
      clr_hit     = '0;
      low_ev      = '0;
      ev_found    = 1'b0;
      rd_cnt_sel  = '0;
      rd_data_sel = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         ev[i]      = push[i] && !(count[i*CW +: CW] < CW'(FIFO_DEPTH));
         clr_hit[i] = clr && (clr_ch == IW'(i));
         if (ev[i] && !ev_found) begin
            low_ev   = IW'(i);
            ev_found = 1'b1;
         end
         if (rd_ch == IW'(i)) begin
            rd_cnt_sel  = cnt[i];
            rd_data_sel = cap[i];
         end
      end
   end

   // An event on a channel being cleared restarts it as a fresh first overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_flag <= '0;
         for (int unsigned i = 0; i < NCH; i++) begin
            cnt[i] <= '0;
            cap[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NCH; i++) begin
            if (ev[i]) begin
               ovf_flag[i] <= 1'b1;
               if (clr_hit[i] || !ovf_flag[i]) begin
                  cnt[i] <= CNT_W'(1);
                  cap[i] <= data[i*PCKG_SZ +: PCKG_SZ];
               end else if (cnt[i] != '1) begin
                  cnt[i] <= cnt[i] + 1'b1;
               end
            end else if (clr_hit[i]) begin
               ovf_flag[i] <= 1'b0;
               cnt[i]      <= '0;
               cap[i]      <= '0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         any_ovf  <= 1'b0;
         first_ch <= '0;
         rd_cnt   <= '0;
         rd_data  <= '0;
      end else begin
         any_ovf <= |ovf_flag;
         if (!any_ovf && ev_found) begin
            first_ch <= low_ev;
         end
         rd_cnt  <= rd_cnt_sel;
         rd_data <= rd_data_sel;
      end
   end

`ifdef FIFO_HWM_EN
   logic [CW-1:0] hwm [NCH];
   logic [CW-1:0] rd_hwm_sel;

   always_comb begin
      rd_hwm_sel = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (rd_ch == IW'(i)) begin
            rd_hwm_sel = hwm[i];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_hwm <= '0;
         for (int unsigned i = 0; i < NCH; i++) begin
            hwm[i] <= '0;
         end
      end else begin
         rd_hwm <= rd_hwm_sel;
         for (int unsigned i = 0; i < NCH; i++) begin
            if (count[i*CW +: CW] > hwm[i]) begin
               hwm[i] <= count[i*CW +: CW];
            end
         end
      end
   end
`else
   assign rd_hwm = '0;
`endif

endmodule
